ca_beat_serializer: RTL

Downstream stage of the CA packetizer. It accepts 40-bit formatted CA beats (32-bit payload plus 8-bit nibble parity) over ready/valid and checks the parity. It buffers beats in a small FIFO and drives them toward the PHY as two 16-bit unit intervals (UIs), with a per-rank active-low chip select decoded from the payload rank field. It also counts parity and rank errors for status readback.

---
 rtl/ca_beat_serializer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ca_beat_serializer.sv
// ca_beat_serializer
// Accepts 40-bit CA beats (payload [31:0], nibble parity [39:32]) over
// ready/valid, checks parity and the rank field, buffers the beats in a
// small FIFO and drives each one toward the PHY as two 16-bit UIs with a
// per-rank active-low chip select.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   ca_data_i         formatted CA beat
//   ca_valid_i        beat valid
//   ca_ready_o        beat accept, high while FIFO level < FIFO_DEPTH
//   drop_on_err_i     discard beats that fail the check
//   drv_en_i          PHY advance enable, low stalls the output stage
//   ca_out_o          current UI of CA bits
//   cs_n_o            per-rank chip select, active low
//   ca_out_valid_o    ca_out_o/cs_n_o carry a live UI
//   err_pulse_o       one-cycle pulse per failing beat
//   err_count_o       saturating error count
//   fifo_level_o      current FIFO occupancy
module ca_beat_serializer #(
  parameter int unsigned WIDTH_BITS = 40,
  parameter int unsigned RANKS      = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          CHECK_ECC  = 1'b1,
  parameter int unsigned ERR_CNT_W  = 8,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_BITS-1:0] ca_data_i,
  input  logic                  ca_valid_i,
  output logic                  ca_ready_o,
  input  logic                  drop_on_err_i,
  input  logic                  drv_en_i,
  output logic [15:0]           ca_out_o,
  output logic [RANKS-1:0]      cs_n_o,
  output logic                  ca_out_valid_o,
  output logic                  err_pulse_o,
  output logic [ERR_CNT_W-1:0]  err_count_o,
  output logic [LVL_W-1:0]      fifo_level_o
);

  localparam int unsigned RB    = (RANKS > 1) ? $clog2(RANKS) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PAY_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_UI0, S_UI1} state_t;

  state_t             state_q;
  logic [PAY_W-1:0]   sh_q;
  logic [PAY_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LVL_W-1:0]   level_q;

  logic [7:0]         exp_par;
  logic [RB-1:0]      rank_in;
  logic               par_err;
  logic               rank_err;
  logic               fail;
  logic               accept;
  logic               push;
  logic               pop;
  logic               not_empty;
  logic [RANKS-1:0]   cs_dec;

  // Expected nibble parity of the incoming payload
  always_comb begin
    exp_par = '0;
    for (int i = 0; i < 8; i++) begin
      exp_par[i] = ^ca_data_i[4*i +: 4];
    end
  end

  assign rank_in   = ca_data_i[24 +: RB];
  assign par_err   = CHECK_ECC && (exp_par != ca_data_i[39:32]);
  assign rank_err  = 32'(rank_in) >= 32'(RANKS);
  assign fail      = par_err || rank_err;

  // Ready looks only at the registered level, so a full FIFO never pushes
  assign ca_ready_o   = level_q < LVL_W'(FIFO_DEPTH);
  assign fifo_level_o = level_q;
  assign accept       = ca_valid_i && ca_ready_o;
  assign push         = accept && !(fail && drop_on_err_i);
  assign not_empty    = level_q != '0;
  assign pop          = not_empty &&
                        ((state_q == S_IDLE) || ((state_q == S_UI1) && drv_en_i));

  // Chip-select decode of the beat in the shift register; out-of-range rank selects nothing
  always_comb begin
    cs_dec = '1;
    for (int r = 0; r < RANKS; r++) begin
      if (32'(sh_q[24 +: RB]) == 32'(r)) begin
        cs_dec[r] = 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // FIFO storage; only the payload travels downstream
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= ca_data_i[PAY_W-1:0];
    end
  end

  // Output FSM; outputs are a registered decode of the current state,
  // which places UI0 two edges after acceptance into an empty FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      sh_q           <= '0;
      ca_out_o       <= '0;
      cs_n_o         <= '1;
      ca_out_valid_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ca_out_valid_o <= 1'b0;
          cs_n_o         <= '1;
          if (not_empty) begin
            sh_q    <= mem[rd_ptr_q];
            state_q <= S_UI0;
          end
        end
        S_UI0: begin
          ca_out_o       <= sh_q[15:0];
          cs_n_o         <= cs_dec;
          ca_out_valid_o <= 1'b1;
          if (drv_en_i) state_q <= S_UI1;
        end
        S_UI1: begin
          ca_out_o       <= sh_q[31:16];
          cs_n_o         <= '1;
          ca_out_valid_o <= 1'b1;
          if (drv_en_i) begin
            if (not_empty) begin
              sh_q    <= mem[rd_ptr_q];
              state_q <= S_UI0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q        <= S_IDLE;
          ca_out_valid_o <= 1'b0;
          cs_n_o         <= '1;
        end
      endcase
    end
  end

  // Error pulse and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse_o <= 1'b0;
      err_count_o <= '0;
    end else begin
      err_pulse_o <= accept && fail;
      if (accept && fail && (err_count_o != '1)) begin
        err_count_o <= err_count_o + ERR_CNT_W'(1);
      end
    end
  end

endmodule
